// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vector-magnitude integer square-root block:
// FSM state type, width derivations from the operand width W, and the
// number of restoring iterations.
package vec_mag_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SQR  = 2'd1,
      ST_ITER = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Root width: sqrt(2*(2^W-1)^2) < 2^(W+1)
   function automatic int unsigned mag_w(input int unsigned w);
      return w + 1;
   endfunction

   // Remainder width: x^2+y^2 needs 2W+1 bits, padded to an even bit-pair count
   function automatic int unsigned rem_w(input int unsigned w);
      return 2 * w + 2;
   endfunction

   // One result bit per iteration
   function automatic int unsigned iter_n(input int unsigned w);
      return w + 1;
   endfunction

   // Counter must reach iter_n(w) inclusive (the commit cycle)
   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/vec_mag_isqrt_if.sv
// Handshake bus for vec_mag_isqrt.
//   master: drives in_valid, x_in, y_in, out_ready (producer/consumer side)
//   slave : drives in_ready, out_valid, mag_out, rem_out (the block)
interface vec_mag_isqrt_if #(
   parameter int unsigned W = 8
);
   import vec_mag_pkg::*;

   localparam int unsigned MW = mag_w(W);
   localparam int unsigned RW = rem_w(W);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x_in;
   logic [W-1:0]  y_in;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] mag_out;
   logic [RW-1:0] rem_out;

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, mag_out, rem_out
   );

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, mag_out, rem_out
   );

endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root iteration (combinational).
//   rem_in/root_in : partial remainder and root so far
//   pair_in        : next two radicand bits, MSB first
//   rem_out/root_out: updated remainder and root (one more root bit)
module isqrt_step
   import vec_mag_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [rem_w(W)-1:0] rem_in,
   input  logic [mag_w(W)-1:0] root_in,
   input  logic [1:0]          pair_in,
   output logic [rem_w(W)-1:0] rem_out,
   output logic [mag_w(W)-1:0] root_out
);
   localparam int unsigned MW = mag_w(W);
   localparam int unsigned RW = rem_w(W);

   logic [RW-1:0] rem_sh;
   logic [RW-1:0] trial;

   // Remainder stays below 2^(W+3), so the dropped top bits are always zero
   assign rem_sh = RW'({rem_in, pair_in});
   assign trial  = RW'({root_in, 2'b01});

   always_comb begin
      rem_out  = rem_sh;
      root_out = {root_in[MW-2:0], 1'b0};
      if (rem_sh >= trial) begin
         rem_out  = rem_sh - trial;
         root_out = {root_in[MW-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/vec_mag_isqrt.sv
// Integer magnitude of a 2-D vector: mag = floor(sqrt(x^2 + y^2)),
// rem = x^2 + y^2 - mag^2, computed bit-serially (one root bit per cycle).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - vec_mag_isqrt_if.slave: in_valid/in_ready/x_in/y_in in,
//          out_valid/out_ready/mag_out/rem_out out
// Parameters: W (operand width 4..16), SIGNED_IN (1 = two's complement).
// Build option: VEC_MAG_ROUND_EN rounds mag_out to nearest (rem_out unchanged).
module vec_mag_isqrt
   import vec_mag_pkg::*;
#(
   parameter int unsigned W         = 8,
   parameter bit          SIGNED_IN = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   vec_mag_isqrt_if.slave     bus
);
   localparam int unsigned MW = mag_w(W);
   localparam int unsigned RW = rem_w(W);
   localparam int unsigned SW = 2 * W + 1;
   localparam int unsigned NI = iter_n(W);
   localparam int unsigned CW = cnt_w(W);

   state_t        state;
   logic [W-1:0]  x_q;
   logic [W-1:0]  y_q;
   logic [RW-1:0] s_sh;
   logic [RW-1:0] rem_q;
   logic [MW-1:0] root_q;
   logic [CW-1:0] cnt;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [MW-1:0] mag_q;
   logic [RW-1:0] rem_o_q;

   logic [W-1:0]  ax_c;
   logic [W-1:0]  ay_c;
   logic [SW-1:0] sum_c;
   logic [RW-1:0] rem_nx_c;
   logic [MW-1:0] root_nx_c;

   // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which fits unsigned W bits
   function automatic logic [W-1:0] abs_op(input logic [W-1:0] v);
      if (SIGNED_IN && v[W-1])
         return W'(~v + W'(1));
      return v;
   endfunction

   assign ax_c  = abs_op(x_q);
   assign ay_c  = abs_op(y_q);
   assign sum_c = SW'(ax_c) * SW'(ax_c) + SW'(ay_c) * SW'(ay_c);

   isqrt_step #(.W(W)) u_step (
      .rem_in   (rem_q),
      .root_in  (root_q),
      .pair_in  (s_sh[RW-1 -: 2]),
      .rem_out  (rem_nx_c),
      .root_out (root_nx_c)
   );

   // Control FSM and datapath registers; ports only change on the commit cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         s_sh        <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mag_q       <= '0;
         rem_o_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  x_q        <= bus.x_in;
                  y_q        <= bus.y_in;
                  in_ready_q <= 1'b0;
                  state      <= ST_SQR;
               end
            end
            ST_SQR: begin
               s_sh   <= RW'(sum_c);
               rem_q  <= '0;
               root_q <= '0;
               cnt    <= '0;
               state  <= ST_ITER;
            end
            ST_ITER: begin
               // NI shift/subtract cycles, then one commit cycle to the ports
               if (cnt == CW'(NI)) begin
                  rem_o_q     <= rem_q;
`ifdef VEC_MAG_ROUND_EN
                  mag_q       <= (rem_q > RW'(root_q)) ? root_q + MW'(1) : root_q;
`else
                  mag_q       <= root_q;
`endif
                  out_valid_q <= 1'b1;
                  state       <= ST_HOLD;
               end else begin
                  rem_q  <= rem_nx_c;
                  root_q <= root_nx_c;
                  s_sh   <= s_sh << 2;
                  cnt    <= cnt + CW'(1);
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.mag_out   = mag_q;
   assign bus.rem_out   = rem_o_q;

endmodule

// File: tb/tb_vec_mag_isqrt.sv
// Self-checking bench for vec_mag_isqrt (W=8): one unsigned and one signed
// instance, expected results queued at drive time and compared on output.
module tb_vec_mag_isqrt;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vec_mag_isqrt_if #(.W(W)) bus_u ();
   vec_mag_isqrt_if #(.W(W)) bus_s ();

   vec_mag_isqrt #(.W(W), .SIGNED_IN(1'b0)) dut_u (
      .clk (clk),
      .rst (rst),
      .bus (bus_u)
   );

   vec_mag_isqrt #(.W(W), .SIGNED_IN(1'b1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   typedef struct {
      int mag;
      int rem;
   } res_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: brute-force floor root of x^2+y^2
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit sgn, output int mag, output int rem);
      int ax, ay, s, r;
      ax = int'(x);
      ay = int'(y);
      if (sgn && x[W-1]) ax = 256 - ax;
      if (sgn && y[W-1]) ay = 256 - ay;
      s = ax * ax + ay * ay;
      r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      rem = s - r * r;
      mag = r;
`ifdef VEC_MAG_ROUND_EN
      if (rem > r) mag = r + 1;
`endif
   endfunction

   function automatic logic get_valid(input bit sel);
      return sel ? bus_s.out_valid : bus_u.out_valid;
   endfunction
   function automatic logic get_ready(input bit sel);
      return sel ? bus_s.in_ready : bus_u.in_ready;
   endfunction
   function automatic logic [W:0] get_mag(input bit sel);
      return sel ? bus_s.mag_out : bus_u.mag_out;
   endfunction
   function automatic logic [2*W+1:0] get_rem(input bit sel);
      return sel ? bus_s.rem_out : bus_u.rem_out;
   endfunction

   task automatic drive_in(input bit sel, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
      if (sel) begin
         bus_s.in_valid = v; bus_s.x_in = x; bus_s.y_in = y;
      end else begin
         bus_u.in_valid = v; bus_u.x_in = x; bus_u.y_in = y;
      end
   endtask

   task automatic set_oready(input bit sel, input logic v);
      if (sel) bus_s.out_ready = v;
      else     bus_u.out_ready = v;
   endtask

   // Accept at the next edge; called at a negedge with in_ready already high
   task automatic accept(input bit sel, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
      int n;
      n = 0;
      while (!get_ready(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/in_ready_idle"}, 64'(get_ready(sel)), 64'd1);
      drive_in(sel, 1'b1, x, y);
      @(posedge clk);
      @(negedge clk);
      drive_in(sel, 1'b0, '0, '0);
      chk({tag, "/in_ready_busy"}, 64'(get_ready(sel)), 64'd0);
   endtask

   task automatic run_op(input bit sel, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall, input string tag);
      res_t e;
      int   n;
      model(x, y, sel, e.mag, e.rem);
      sb.push_back(e);
      accept(sel, x, y, tag);
      n = 0;
      while (!get_valid(sel) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/latency"}, 64'(n), 64'(W + 3));
      e = sb.pop_front();
      chk({tag, "/mag"}, 64'(get_mag(sel)), 64'(e.mag));
      chk({tag, "/rem"}, 64'(get_rem(sel)), 64'(e.rem));
      for (int i = 0; i < stall; i++) begin
         drive_in(sel, i[0], ~x, ~y);
         @(negedge clk);
         chk({tag, "/hold_valid"}, 64'(get_valid(sel)), 64'd1);
         chk({tag, "/hold_mag"},   64'(get_mag(sel)),   64'(e.mag));
         chk({tag, "/hold_rem"},   64'(get_rem(sel)),   64'(e.rem));
         chk({tag, "/hold_ready"}, 64'(get_ready(sel)), 64'd0);
      end
      drive_in(sel, 1'b0, '0, '0);
      set_oready(sel, 1'b1);
      @(negedge clk);
      set_oready(sel, 1'b0);
      chk({tag, "/release_valid"}, 64'(get_valid(sel)), 64'd0);
      chk({tag, "/release_ready"}, 64'(get_ready(sel)), 64'd1);
      chk({tag, "/kept_mag"},      64'(get_mag(sel)),   64'(e.mag));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int aborted_hits;
      logic [W-1:0] rx, ry;

      drive_in(1'b0, 1'b0, '0, '0);
      drive_in(1'b1, 1'b0, '0, '0);
      set_oready(1'b0, 1'b0);
      set_oready(1'b1, 1'b0);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset/in_ready",  64'(bus_u.in_ready),  64'd1);
      chk("reset/out_valid", 64'(bus_u.out_valid), 64'd0);
      chk("reset/mag",       64'(bus_u.mag_out),   64'd0);
      chk("reset/rem",       64'(bus_u.rem_out),   64'd0);
      chk("reset/s_ready",   64'(bus_s.in_ready),  64'd1);
      rst = 1'b0;
      @(negedge clk);

      // Unsigned build
      run_op(1'b0, 8'd3,   8'd4,   0, "u_3_4");
      run_op(1'b0, 8'd255, 8'd255, 0, "u_255_255");
      run_op(1'b0, 8'd1,   8'd1,   0, "u_1_1");
      run_op(1'b0, 8'd0,   8'd0,   0, "u_0_0");
      run_op(1'b0, 8'd200, 8'd7,   0, "u_200_7");
      for (int i = 0; i < 6; i++) begin
         rx = W'($urandom_range(0, 255));
         ry = W'($urandom_range(0, 255));
         run_op(1'b0, rx, ry, 0, "u_rand");
      end
      run_op(1'b0, 8'd3, 8'd4, 10, "u_stall");

      // Reset during the 4th ITER cycle aborts the operation
      accept(1'b0, 8'd255, 8'd255, "abort");
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort/out_valid", 64'(bus_u.out_valid), 64'd0);
      chk("abort/mag",       64'(bus_u.mag_out),   64'd0);
      chk("abort/rem",       64'(bus_u.rem_out),   64'd0);
      chk("abort/in_ready",  64'(bus_u.in_ready),  64'd1);
      @(negedge clk);
      rst = 1'b0;
      aborted_hits = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus_u.out_valid) aborted_hits++;
      end
      chk("abort/no_result", 64'(aborted_hits), 64'd0);
      run_op(1'b0, 8'd6, 8'd8, 0, "u_after_abort");

      // Signed build
      run_op(1'b1, 8'hFD, 8'h04, 0, "s_m3_4");
      run_op(1'b1, 8'h80, 8'h00, 0, "s_m128_0");
      run_op(1'b1, 8'h80, 8'h80, 0, "s_m128_m128");
      run_op(1'b1, 8'h7F, 8'h81, 0, "s_127_m127");
      run_op(1'b1, 8'hFF, 8'hFF, 0, "s_m1_m1");
      for (int i = 0; i < 4; i++) begin
         rx = W'($urandom_range(0, 255));
         ry = W'($urandom_range(0, 255));
         run_op(1'b1, rx, ry, 0, "s_rand");
      end

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_mag_isqrt.md
VEC_MAG_ISQRT -- requirements
Module: vec_mag_isqrt

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits, legal range 4..16.
REQ-002 SHALL have parameter SIGNED_IN, default 0: 1 = operands are two's complement, 0 = unsigned.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block idle, will accept operands.
REQ-007 SHALL have port x_in  input  W  first vector component.
REQ-008 SHALL have port y_in  input  W  second vector component.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port mag_out  output  W+1  integer magnitude of (x,y).
REQ-012 SHALL have port rem_out  output  2W+2  square-root remainder, sum minus floor-root squared.

Function
REQ-013 SHALL run an FSM with states IDLE, SQR, ITER, HOLD.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, SHALL register x_in and y_in and go to SQR.
REQ-015 SQR: SHALL take absolute values when SIGNED_IN=1, e.g. -2^(W-1) becomes 2^(W-1) with no overflow; SHALL form S = x^2 + y^2 at full 2W+1 width; go to ITER.
REQ-016 ITER: SHALL perform restoring bit-serial square root, one result bit per cycle, MSB first, exactly W+1 cycles, using an iteration counter; then go to HOLD.
REQ-017 HOLD: out_valid=1, mag_out and rem_out stable; on out_ready=1 SHALL return to IDLE.
REQ-018 Latency: out_valid SHALL rise exactly W+3 clock edges after the accepting edge, independent of operand values and of the configuration macro.
REQ-019 in_ready SHALL be 0 in SQR, ITER and HOLD; in_valid there SHALL be ignored with no queuing.
REQ-020 No back-to-back overlap: the earliest next accept is the edge after the HOLD-to-IDLE transition.
REQ-021 mag_out and rem_out SHALL hold their last values outside HOLD; no mid-iteration values SHALL be visible on the ports.
REQ-022 Unrounded result: mag_out = floor(sqrt(S)), rem_out = S - mag_out^2.
REQ-023 S = 0 SHALL yield mag_out=0, rem_out=0 with normal latency.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, mag_out=0, rem_out=0, and clear all internal registers.
REQ-025 Reset asserted in any state, including mid-ITER, SHALL abort the operation with no result produced.
REQ-026 The first accept after reset release SHALL occur no earlier than the first clk edge with rst=0.

Configuration
REQ-027 Macro VEC_MAG_ROUND_EN: when defined, mag_out SHALL be rounded to nearest, incrementing the floor root r when S - r^2 > r; rem_out SHALL still report S - r^2 for the floor root.
REQ-028 When VEC_MAG_ROUND_EN is undefined, mag_out SHALL be the floor root and no rounding logic SHALL be present.
REQ-029 The rounded result SHALL always fit in W+1 bits, and latency SHALL be unchanged with or without the macro.

Structure
REQ-030 A shared package vec_mag_pkg SHALL hold the FSM state typedef, the width helper constants (W+1 and 2W+2 derivation), and the iteration-count constant.
REQ-031 A single sub-module isqrt_step SHALL implement one restoring-iteration datapath, combinational: remainder, root and trial-subtract in, updated remainder and root out; it is instanced once in vec_mag_isqrt.

Verification (W=8)
REQ-032 (x=3, y=4) -> mag_out=5, rem_out=0, out_valid exactly 11 edges after accept.
REQ-033 (255,255) -> floor: mag_out=360, rem_out=450; with VEC_MAG_ROUND_EN: mag_out=361, rem_out=450.
REQ-034 (1,1) -> mag_out=1, rem_out=1 in both builds; (0,0) -> 0,0.
REQ-035 SIGNED_IN=1, x=0xFD (-3), y=0x04 -> 5; x=0x80, y=0x00 -> 128.
REQ-036 out_ready held low 10 cycles in HOLD -> out_valid, mag_out and rem_out stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-037 rst pulsed during the 4th ITER cycle -> outputs zero immediately, no out_valid; next operation (6,8) -> 10.
